// File: rtl/pc_npc_fetch_stage.sv
// pc_npc_fetch_stage: PC/nPC fetch stage with one branch delay slot.
// Keeps the PC/nPC pair, drives the instruction-memory address and owns the IF/ID register.
// Inputs: clk, reset (synchronous, active high), le (0 = stall),
//   branch_taken, branch_target_pc, imem_instr.
// Outputs: imem_addr, pc_out, npc_out, ifid_instr, ifid_pc,
//   ifid_valid, redirect_pending.
// Optional: `define NULLIFY_DELAY_SLOT_EN to squash the delay slot and
//   redirect the PC directly when a redirect is accepted.
module pc_npc_fetch_stage #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             le,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target_pc,
    input  logic [WIDTH-1:0] imem_instr,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] npc_out,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc,
    output logic             ifid_valid,
    output logic             redirect_pending
);

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] npc_q;
    logic [WIDTH-1:0] pend_q;

    logic [WIDTH-1:0] live_tgt;
    logic [WIDTH-1:0] tgt;
    logic             redir;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] npc_d;
    logic [WIDTH-1:0] ifid_instr_d;
    logic             ifid_valid_d;

    // Targets are always word aligned.
    assign live_tgt = {branch_target_pc[WIDTH-1:2], 2'b00};

    // Values loaded when the stage advances. Releasing a HOLD always
    // redirects; a live branch beats the pending one.
    always_comb begin
        redir        = (state == HOLD) || branch_taken;
        tgt          = (state == HOLD && !branch_taken) ? pend_q : live_tgt;
        pc_d         = npc_q;
        npc_d        = redir ? tgt : npc_q + FOUR;
        ifid_instr_d = imem_instr;
        ifid_valid_d = 1'b1;
`ifdef NULLIFY_DELAY_SLOT_EN
        if (redir) begin
            pc_d         = tgt;
            npc_d        = tgt + FOUR;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= BOOT;
            pc_q             <= RESET_PC;
            npc_q            <= RESET_PC + FOUR;
            pend_q           <= '0;
            ifid_instr       <= '0;
            ifid_pc          <= '0;
            ifid_valid       <= 1'b0;
            redirect_pending <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (le) begin
                        pc_q       <= pc_d;
                        npc_q      <= npc_d;
                        ifid_instr <= ifid_instr_d;
                        ifid_pc    <= pc_q;
                        ifid_valid <= ifid_valid_d;
                    end else if (branch_taken) begin
                        pend_q           <= live_tgt;
                        redirect_pending <= 1'b1;
                        state            <= HOLD;
                    end
                end
                HOLD: begin
                    if (le) begin
                        pc_q             <= pc_d;
                        npc_q            <= npc_d;
                        ifid_instr       <= ifid_instr_d;
                        ifid_pc          <= pc_q;
                        ifid_valid       <= ifid_valid_d;
                        pend_q           <= '0;
                        redirect_pending <= 1'b0;
                        state            <= RUN;
                    end else if (branch_taken) begin
                        pend_q <= live_tgt;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign npc_out   = npc_q;

endmodule

// File: tb/tb_pc_npc_fetch_stage.sv
// tb_pc_npc_fetch_stage: directed scoreboard bench for pc_npc_fetch_stage.
// Stimulus queues expected state per edge; a monitor pops and compares.
module tb_pc_npc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        le = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target_pc = '0;
    logic [31:0] imem_instr = '0;
    logic [31:0] imem_addr;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        redirect_pending;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ipc;
        logic [31:0] iins;
        logic        iv;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];
    int   step_id = 0;

    pc_npc_fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .le               (le),
        .branch_taken     (branch_taken),
        .branch_target_pc (branch_target_pc),
        .imem_instr       (imem_instr),
        .imem_addr        (imem_addr),
        .pc_out           (pc_out),
        .npc_out          (npc_out),
        .ifid_instr       (ifid_instr),
        .ifid_pc          (ifid_pc),
        .ifid_valid       (ifid_valid),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL step %0d %s: got %h expected %h",
                      id, name, act, exp);
    endtask

    // Monitor: the DUT presents new state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.id, "pc_out", pc_out, e.pc);
                chk(e.id, "imem_addr", imem_addr, e.pc);
                chk(e.id, "npc_out", npc_out, e.npc);
                chk(e.id, "ifid_pc", ifid_pc, e.ipc);
                chk(e.id, "ifid_instr", ifid_instr, e.iins);
                chk(e.id, "ifid_valid", {31'b0, ifid_valid}, {31'b0, e.iv});
                chk(e.id, "redirect_pending",
                    {31'b0, redirect_pending}, {31'b0, e.pend});
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic bt,
                        input logic [31:0] tg, input logic [31:0] ins,
                        input logic [31:0] e_pc, input logic [31:0] e_npc,
                        input logic [31:0] e_ipc, input logic [31:0] e_iins,
                        input logic e_iv, input logic e_pend);
        exp_t e;
        @(negedge clk);
        reset = r;
        le = l;
        branch_taken = bt;
        branch_target_pc = tg;
        imem_instr = ins;
        step_id++;
        e.id = step_id;
        e.pc = e_pc;
        e.npc = e_npc;
        e.ipc = e_ipc;
        e.iins = e_iins;
        e.iv = e_iv;
        e.pend = e_pend;
        exp_q.push_back(e);
    endtask

    initial begin
        int budget;
        //   rst le bt target        instr         pc            npc           ifid_pc       ifid_ins v p
        step(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0,        32'h0,   0, 0);
        // BOOT: branch ignored, no advance
        step(0, 1, 1, 32'h100,      32'h11,       32'h0,        32'h4,        32'h0,        32'h0,   0, 0);
        step(0, 1, 0, 32'h0,        32'hA0,       32'h4,        32'h8,        32'h0,        32'hA0,  1, 0);
        step(0, 1, 0, 32'h0,        32'hA4,       32'h8,        32'hC,        32'h4,        32'hA4,  1, 0);
        // branch at PC=8 to 0x40, delay slot at 12
        step(0, 1, 1, 32'h40,       32'hA8,       32'hC,        32'h40,       32'h8,        32'hA8,  1, 0);
        step(0, 1, 0, 32'h0,        32'hAC,       32'h40,       32'h44,       32'hC,        32'hAC,  1, 0);
        step(0, 1, 0, 32'h0,        32'hB0,       32'h44,       32'h48,       32'h40,       32'hB0,  1, 0);
        // plain stall, instruction input changing
        step(0, 0, 0, 32'h0,        32'hDEAD1,    32'h44,       32'h48,       32'h40,       32'hB0,  1, 0);
        step(0, 0, 0, 32'h0,        32'hDEAD2,    32'h44,       32'h48,       32'h40,       32'hB0,  1, 0);
        step(0, 0, 0, 32'h0,        32'hDEAD3,    32'h44,       32'h48,       32'h40,       32'hB0,  1, 0);
        // redirect during stall, last wins
        step(0, 0, 1, 32'h80,       32'h1,        32'h44,       32'h48,       32'h40,       32'hB0,  1, 1);
        step(0, 0, 1, 32'h90,       32'h2,        32'h44,       32'h48,       32'h40,       32'hB0,  1, 1);
        step(0, 0, 0, 32'h0,        32'h3,        32'h44,       32'h48,       32'h40,       32'hB0,  1, 1);
        step(0, 1, 0, 32'h0,        32'hC4,       32'h48,       32'h90,       32'h44,       32'hC4,  1, 0);
        step(0, 1, 0, 32'h0,        32'hC8,       32'h90,       32'h94,       32'h48,       32'hC8,  1, 0);
        // HOLD release with live branch: live target wins, low bits masked
        step(0, 0, 1, 32'h200,      32'h4,        32'h90,       32'h94,       32'h48,       32'hC8,  1, 1);
        step(0, 1, 1, 32'h303,      32'hCC,       32'h94,       32'h300,      32'h90,       32'hCC,  1, 0);
        step(0, 1, 0, 32'h0,        32'hD0,       32'h300,      32'h304,      32'h94,       32'hD0,  1, 0);
        // wrap-around at the top of the address space
        step(0, 1, 1, 32'hFFFFFFF8, 32'hD4,       32'h304,      32'hFFFFFFF8, 32'h300,      32'hD4,  1, 0);
        step(0, 1, 0, 32'h0,        32'hD8,       32'hFFFFFFF8, 32'hFFFFFFFC, 32'h304,      32'hD8,  1, 0);
        step(0, 1, 0, 32'h0,        32'hE0,       32'hFFFFFFFC, 32'h0,        32'hFFFFFFF8, 32'hE0,  1, 0);
        step(0, 1, 0, 32'h0,        32'hE4,       32'h0,        32'h4,        32'hFFFFFFFC, 32'hE4,  1, 0);
        step(0, 1, 1, 32'h43,       32'hE8,       32'h4,        32'h40,       32'h0,        32'hE8,  1, 0);
        step(0, 1, 0, 32'h0,        32'hEC,       32'h40,       32'h44,       32'h4,        32'hEC,  1, 0);
        // reset while in HOLD discards the pending redirect
        step(0, 0, 1, 32'h500,      32'h0,        32'h40,       32'h44,       32'h4,        32'hEC,  1, 1);
        step(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0,        32'h0,   0, 0);
        step(0, 1, 0, 32'h0,        32'hF0,       32'h0,        32'h4,        32'h0,        32'h0,   0, 0);
        step(0, 1, 0, 32'h0,        32'hF4,       32'h4,        32'h8,        32'h0,        32'hF4,  1, 0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_npc_fetch_stage.md
Name: pc_npc_fetch_stage

Overview:
- Fetch stage that sits directly upstream of the branch condition handler. It consumes that block's `branch_taken` / `branch_target_pc` and feeds the ID stage.
- Holds the architectural PC/nPC pair with MIPS one-delay-slot semantics, and drives the instruction-memory address.
- Owns the IF/ID pipeline register.
- Handles hazard stalls, including a branch redirect that arrives while stalled.

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset; nPC resets to `RESET_PC+4`.
- `WIDTH`, 32, address and instruction width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `le`  in  1  load enable from hazard unit; 0 = stall (hold PC, nPC, IF/ID).
- `branch_taken`  in  1  redirect request from condition handler, resolved in ID.
- `branch_target_pc`  in  WIDTH  redirect target.
- `imem_instr`  in  WIDTH  instruction read combinationally at `imem_addr`.
- `imem_addr`  out  WIDTH  equals `pc_out`.
- `pc_out`  out  WIDTH  current PC register.
- `npc_out`  out  WIDTH  current nPC register.
- `ifid_instr`  out  WIDTH  IF/ID instruction register.
- `ifid_pc`  out  WIDTH  PC of the instruction in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `redirect_pending`  out  1  high in state HOLD.

Behaviour:
- Reset (sync, overrides everything): PC=`RESET_PC`, nPC=`RESET_PC+4`, `ifid_instr`=0, `ifid_pc`=0, `ifid_valid`=0, pending target=0, `redirect_pending`=0, state=BOOT.
- Targets: `branch_target_pc[1:0]` is forced to 00 on capture/use.
- Arithmetic: all adds are modulo 2^WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- States:
  - BOOT: one cycle after reset release; no PC advance, `ifid_valid` stays 0; unconditionally -> RUN.
  - RUN, `le`=1:
    - `ifid_instr` <= `imem_instr`, `ifid_pc` <= PC, `ifid_valid` <= 1.
    - PC <= nPC.
    - nPC <= `branch_taken` ? target : nPC+4.
    - Net effect: the instruction fetched this cycle is the delay slot and executes.
  - RUN, `le`=0:
    - Hold PC, nPC, IF/ID.
    - If `branch_taken`=1: pending target <= target, -> HOLD.
  - HOLD, `le`=0:
    - Hold PC, nPC, IF/ID.
    - If `branch_taken`=1 again, overwrite pending target (last wins).
  - HOLD, `le`=1:
    - Load IF/ID as in RUN; PC <= nPC.
    - nPC <= `branch_taken` ? live target : pending target (live input has priority).
    - Clear pending; -> RUN.
- Latency: redirect visible on `npc_out` 1 edge after acceptance and on `pc_out` 2 edges after.
- `branch_taken` is ignored in BOOT.
- Reset asserted in any state, including HOLD, discards the pending redirect.

Optional Feature:
- Macro: `NULLIFY_DELAY_SLOT_EN`.
- Defined: on an accepted redirect (RUN with `le`=1 and `branch_taken`, or HOLD release):
  - PC <= target, nPC <= target+4.
  - `ifid_instr` <= 0, `ifid_valid` <= 0 (delay slot squashed).
  - Redirect visible on `pc_out` after 1 edge.
- Undefined: delay-slot behaviour exactly as above; no squash logic is synthesized.

Test Plan:
- Reset with `RESET_PC`=0 -> `pc_out`=0, `npc_out`=4, `ifid_valid`=0; `pc_out` stays 0 for the BOOT cycle, then steps 4, 8, 12 with `le`=1.
- At PC=8 (nPC=12), `branch_taken`=1, target=0x40, `le`=1 -> next edge PC=12, nPC=0x40, `ifid_pc`=8; following edge PC=0x40, `ifid_pc`=12 (delay slot).
- `le`=0 for 3 cycles with `imem_instr` changing -> PC, nPC, `ifid_instr` unchanged; `ifid_valid` unchanged.
- Stall with `branch_taken`=1, target=0x80 then 0x90 while `le`=0, released with `branch_taken`=0 -> `redirect_pending`=1 during the stall; nPC=0x90 on release, pending cleared.
- PC=0xFFFF_FFF8, no branch -> sequence FFFF_FFFC, 0, 4; target 0x43 -> nPC=0x40.
- `NULLIFY_DELAY_SLOT_EN` build: branch at PC=8 to 0x40 -> next edge PC=0x40, nPC=0x44, `ifid_valid`=0, `ifid_instr`=0. Reset asserted in HOLD -> `redirect_pending`=0, PC=`RESET_PC`.
